// File: rtl/arcade_input_ctrl_pkg.sv
// Shared constants for the arcade input conditioner: joystick word bit layout
// and the coin pulse state encoding.
package arcade_input_pkg;

    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_BTN0  = 4;

    // Control bits sit directly above the action buttons, so they move with BTN_W.
    function automatic int start_bit(input int btn_w);
        return JOY_BTN0 + btn_w;
    endfunction

    function automatic int coin_bit(input int btn_w);
        return JOY_BTN0 + btn_w + 1;
    endfunction

    function automatic int pause_bit(input int btn_w);
        return JOY_BTN0 + btn_w + 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } coin_state_t;

endpackage

// File: rtl/arcade_input_ctrl_if.sv
// Bundle between the hps_io joystick side (master) and the input conditioner (slave).
interface arcade_input_ctrl_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int BTN_W       = 4
);
    logic [16*NUM_PLAYERS-1:0]    joy_in;
    logic                         cocktail;
    logic                         freeze;
    logic [4*NUM_PLAYERS-1:0]     dir_out;
    logic [BTN_W*NUM_PLAYERS-1:0] btn_out;
    logic [NUM_PLAYERS-1:0]       start_out;
    logic [NUM_PLAYERS-1:0]       coin_out;
    logic [8*NUM_PLAYERS-1:0]     coin_count;
    logic                         pause_out;

    modport master (
        output joy_in, cocktail, freeze,
        input  dir_out, btn_out, start_out, coin_out, coin_count, pause_out
    );

    modport slave (
        input  joy_in, cocktail, freeze,
        output dir_out, btn_out, start_out, coin_out, coin_count, pause_out
    );
endinterface

// File: rtl/arcade_input_ctrl_coin_pulse_shaper.sv
// One coin channel: turns a single-cycle rise into a fixed-width pulse followed
// by a lockout gap, and keeps a wrapping 8-bit coin meter.
module coin_pulse_shaper
    import arcade_input_pkg::*;
#(
    parameter int PULSE_CYC = 600000,
    parameter int GAP_CYC   = 1200000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       rise_i,
    input  logic       enable_i,
    output logic       coin_o,
    output logic [7:0] count_o
);

    localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] ONE        = CW'(1);

    coin_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          coin_q, coin_d;
    logic [7:0]    count_q, count_d;

    // enable only gates acceptance in IDLE, so a freeze arriving mid-pulse never cuts it short.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        coin_d  = coin_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (rise_i && enable_i) begin
                    state_d = ACTIVE;
                    cnt_d   = PULSE_LOAD;
                    coin_d  = 1'b1;
                    count_d = count_q + 8'd1;
                end
            end
            ACTIVE: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                    coin_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                coin_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            coin_q  <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            coin_q  <= coin_d;
            count_q <= count_d;
        end
    end

    assign coin_o  = coin_q;
    assign count_o = count_q;

endmodule

// File: rtl/arcade_input_ctrl.sv
// N-player joystick conditioner for arcade cores: cocktail swap, SOCD cleaning,
// latched pause toggle and per-player shaped coin pulses with meters.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int BTN_W          = 4,
    parameter int SOCD_NEUTRAL   = 1,
    parameter int COIN_PULSE_CYC = 600000,
    parameter int COIN_GAP_CYC   = 1200000
) (
    input  logic                clk_sys,
    input  logic                reset,
    arcade_input_ctrl_if.slave  bus
);

    localparam int SB = start_bit(BTN_W);
    localparam int CB = coin_bit(BTN_W);
    localparam int PB = pause_bit(BTN_W);

    logic [16*NUM_PLAYERS-1:0]    joyMapped, joy_q, joy_q2;
    logic [4*NUM_PLAYERS-1:0]     dirClean, dir_q;
    logic [BTN_W*NUM_PLAYERS-1:0] btnRaw, btn_q;
    logic [NUM_PLAYERS-1:0]       startRaw, start_q;
    logic [NUM_PLAYERS-1:0]       coinRise_d, coinRise_q, pauseRise;
    logic [NUM_PLAYERS-1:0]       coinOutVec;
    logic [8*NUM_PLAYERS-1:0]     countVec;
    logic                         pause_q, pause_d;
    logic                         unusedPipeBits;

    generate
        if (NUM_PLAYERS >= 2) begin : g_swap
            always_comb begin
                joyMapped = bus.joy_in;
                if (bus.cocktail) begin
                    joyMapped[15:0]  = bus.joy_in[31:16];
                    joyMapped[31:16] = bus.joy_in[15:0];
                end
            end
        end else begin : g_noswap
            logic unusedCocktail;
            assign joyMapped      = bus.joy_in;
            assign unusedCocktail = bus.cocktail;
        end
    endgenerate

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [3:0] d;

        always_comb begin
            d = joy_q[16*p +: 4];
            if (SOCD_NEUTRAL != 0) begin
                if (d[JOY_LEFT] && d[JOY_RIGHT]) begin
                    d[JOY_LEFT]  = 1'b0;
                    d[JOY_RIGHT] = 1'b0;
                end
                if (d[JOY_UP] && d[JOY_DOWN]) begin
                    d[JOY_UP]   = 1'b0;
                    d[JOY_DOWN] = 1'b0;
                end
            end
        end

        assign dirClean[4*p +: 4]       = d;
        assign btnRaw[BTN_W*p +: BTN_W] = joy_q[16*p+JOY_BTN0 +: BTN_W];
        assign startRaw[p]              = joy_q[16*p+SB];
        assign coinRise_d[p]            = joy_q[16*p+CB] & ~joy_q2[16*p+CB];
        assign pauseRise[p]             = joy_q[16*p+PB] & ~joy_q2[16*p+PB];

        coin_pulse_shaper #(
            .PULSE_CYC (COIN_PULSE_CYC),
            .GAP_CYC   (COIN_GAP_CYC)
        ) u_coin (
            .clk_sys  (clk_sys),
            .reset    (reset),
            .rise_i   (coinRise_q[p]),
            .enable_i (~pause_q & ~bus.freeze),
            .coin_o   (coinOutVec[p]),
            .count_o  (countVec[8*p +: 8])
        );
    end

    // Pipeline bits the game never looks at are folded here so nothing dangles.
    assign unusedPipeBits = ^{joy_q, joy_q2};

    assign pause_d = bus.freeze ? 1'b0 : ((|pauseRise) ? ~pause_q : pause_q);

    // Masking with pause_d keeps the game inputs dark on exactly the cycles pause_out is high.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            joy_q      <= '0;
            joy_q2     <= '0;
            coinRise_q <= '0;
            pause_q    <= 1'b0;
            dir_q      <= '0;
            btn_q      <= '0;
            start_q    <= '0;
        end else begin
            joy_q      <= joyMapped;
            joy_q2     <= joy_q;
            coinRise_q <= coinRise_d;
            pause_q    <= pause_d;
            dir_q      <= pause_d ? '0 : dirClean;
            btn_q      <= pause_d ? '0 : btnRaw;
            start_q    <= pause_d ? '0 : startRaw;
        end
    end

    assign bus.dir_out    = dir_q;
    assign bus.btn_out    = btn_q;
    assign bus.start_out  = start_q;
    assign bus.coin_out   = coinOutVec;
    assign bus.coin_count = countVec;
    assign bus.pause_out  = pause_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl: a vector table for mapping/SOCD/cocktail
// plus hand-written coin, pause and reset sequences on two SOCD variants.
module tb_arcade_input_ctrl;
    import arcade_input_pkg::*;

    localparam int NP     = 2;
    localparam int BW     = 4;
    localparam int PULSE  = 8;
    localparam int GAPC   = 16;
    localparam int COINB  = 9;
    localparam int PAUSEB = 10;

    logic clk_sys = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl_if #(.NUM_PLAYERS(NP), .BTN_W(BW)) busN ();
    arcade_input_ctrl_if #(.NUM_PLAYERS(NP), .BTN_W(BW)) busR ();

    assign busR.joy_in   = busN.joy_in;
    assign busR.cocktail = busN.cocktail;
    assign busR.freeze   = busN.freeze;

    arcade_input_ctrl #(
        .NUM_PLAYERS(NP), .BTN_W(BW), .SOCD_NEUTRAL(1),
        .COIN_PULSE_CYC(PULSE), .COIN_GAP_CYC(GAPC)
    ) dutN (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (busN)
    );

    arcade_input_ctrl #(
        .NUM_PLAYERS(NP), .BTN_W(BW), .SOCD_NEUTRAL(0),
        .COIN_PULSE_CYC(PULSE), .COIN_GAP_CYC(GAPC)
    ) dutR (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (busR)
    );

    typedef struct {
        logic [31:0] joy;
        logic        cocktail;
        logic [7:0]  expDir;
        logic [7:0]  expDirRaw;
        logic [7:0]  expBtn;
        logic [1:0]  expStart;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        busN.joy_in   = v.joy;
        busN.cocktail = v.cocktail;
        tick();
        tick();
        checkOutput($sformatf("vec%0d dir", idx), 32'(busN.dir_out), 32'(v.expDir));
        checkOutput($sformatf("vec%0d dirRaw", idx), 32'(busR.dir_out), 32'(v.expDirRaw));
        checkOutput($sformatf("vec%0d btn", idx), 32'(busN.btn_out), 32'(v.expBtn));
        checkOutput($sformatf("vec%0d start", idx), 32'(busN.start_out), 32'(v.expStart));
    endtask

    // Coin bit of input word inP follows pat[c] before edge c; coin_out[outP] is watched after it.
    task automatic runCoin(input int inP, input int outP, input logic [199:0] pat, input int n,
                           output int rises, output int highs, output int firstRise, output int lastRise);
        logic prev, cur;
        prev = busN.coin_out[outP];
        rises = 0; highs = 0; firstRise = -1; lastRise = -1;
        for (int c = 1; c <= n; c++) begin
            busN.joy_in[16*inP+COINB] = pat[c];
            tick();
            cur = busN.coin_out[outP];
            if (cur) highs++;
            if (cur && !prev) begin
                rises++;
                if (firstRise < 0) firstRise = c;
                lastRise = c;
            end
            prev = cur;
        end
        busN.joy_in[16*inP+COINB] = 1'b0;
    endtask

    task automatic tapPause(input logic [31:0] mask);
        busN.joy_in = busN.joy_in | mask;
        tick();
        busN.joy_in = busN.joy_in & ~mask;
        tick();
        tick();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [199:0] pat;
        int rises, highs, firstRise, lastRise;
        int expCount0;

        vecs[0] = '{32'h0000_0001, 1'b0, 8'h01, 8'h01, 8'h00, 2'b00};
        vecs[1] = '{32'h000B_0000, 1'b0, 8'h80, 8'hB0, 8'h00, 2'b00};
        vecs[2] = '{32'h0000_000E, 1'b0, 8'h02, 8'h0E, 8'h00, 2'b00};
        vecs[3] = '{32'h000F_000F, 1'b0, 8'h00, 8'hFF, 8'h00, 2'b00};
        vecs[4] = '{32'h0020_0090, 1'b0, 8'h00, 8'h00, 8'h29, 2'b00};
        vecs[5] = '{32'h0100_0100, 1'b0, 8'h00, 8'h00, 8'h00, 2'b11};
        vecs[6] = '{32'h0000_0010, 1'b1, 8'h00, 8'h00, 8'h10, 2'b00};
        vecs[7] = '{32'h0100_0001, 1'b1, 8'h10, 8'h10, 8'h00, 2'b01};
        vecs[8] = '{32'h0003_0000, 1'b1, 8'h00, 8'h03, 8'h00, 2'b00};

        reset         = 1'b1;
        busN.joy_in   = '0;
        busN.cocktail = 1'b0;
        busN.freeze   = 1'b0;
        idle(3);
        checkOutput("reset dir", 32'(busN.dir_out), 32'h0);
        checkOutput("reset btn", 32'(busN.btn_out), 32'h0);
        checkOutput("reset start", 32'(busN.start_out), 32'h0);
        checkOutput("reset coin", 32'(busN.coin_out), 32'h0);
        checkOutput("reset count", 32'(busN.coin_count), 32'h0);
        checkOutput("reset pause", 32'(busN.pause_out), 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);
        busN.joy_in   = '0;
        busN.cocktail = 1'b0;
        idle(4);
        expCount0 = 0;

        // Single tap: pulse starts on the third edge and lasts PULSE cycles.
        pat = '0; pat[1] = 1'b1;
        runCoin(0, 0, pat, 30, rises, highs, firstRise, lastRise);
        expCount0 = 1;
        checkOutput("tap rises", 32'(rises), 32'd1);
        checkOutput("tap width", 32'(highs), 32'(PULSE));
        checkOutput("tap latency", 32'(firstRise), 32'd3);
        checkOutput("tap count", 32'(busN.coin_count[7:0]), 32'(expCount0));
        idle(30);

        // Spam during ACTIVE and GAP is dropped; a tap after the gap is honoured.
        pat = '0; pat[1] = 1'b1; pat[5] = 1'b1; pat[13] = 1'b1; pat[31] = 1'b1;
        runCoin(0, 0, pat, 60, rises, highs, firstRise, lastRise);
        expCount0 = 3;
        checkOutput("spam rises", 32'(rises), 32'd2);
        checkOutput("spam width", 32'(highs), 32'(2*PULSE));
        checkOutput("spam second start", 32'(lastRise), 32'd33);
        checkOutput("spam count", 32'(busN.coin_count[7:0]), 32'(expCount0));
        idle(30);

        pat = '0;
        for (int c = 1; c <= 100; c++) pat[c] = 1'b1;
        runCoin(0, 0, pat, 140, rises, highs, firstRise, lastRise);
        expCount0 = 4;
        checkOutput("hold rises", 32'(rises), 32'd1);
        checkOutput("hold width", 32'(highs), 32'(PULSE));
        checkOutput("hold count", 32'(busN.coin_count[7:0]), 32'(expCount0));
        idle(30);

        // Pause: P1 tap latches pause and blanks game inputs and coins.
        busN.joy_in = 32'h0000_0111;
        idle(3);
        checkOutput("prepause dir", 32'(busN.dir_out), 32'h01);
        tapPause(32'h1 << (16 + PAUSEB));
        checkOutput("pause on", 32'(busN.pause_out), 32'h1);
        checkOutput("pause dir", 32'(busN.dir_out), 32'h0);
        checkOutput("pause btn", 32'(busN.btn_out), 32'h0);
        checkOutput("pause start", 32'(busN.start_out), 32'h0);
        pat = '0; pat[1] = 1'b1;
        runCoin(0, 0, pat, 30, rises, highs, firstRise, lastRise);
        checkOutput("pause coin rises", 32'(rises), 32'd0);
        checkOutput("pause coin count", 32'(busN.coin_count[7:0]), 32'(expCount0));
        tapPause((32'h1 << PAUSEB) | (32'h1 << (16 + PAUSEB)));
        checkOutput("dual pause off", 32'(busN.pause_out), 32'h0);
        checkOutput("unpause dir", 32'(busN.dir_out), 32'h01);
        tapPause(32'h1 << PAUSEB);
        checkOutput("pause on again", 32'(busN.pause_out), 32'h1);
        busN.freeze = 1'b1;
        tick();
        checkOutput("freeze clears pause", 32'(busN.pause_out), 32'h0);
        tapPause(32'h1 << (16 + PAUSEB));
        checkOutput("freeze ignores pause", 32'(busN.pause_out), 32'h0);
        runCoin(0, 0, pat, 30, rises, highs, firstRise, lastRise);
        checkOutput("freeze coin rises", 32'(rises), 32'd0);
        busN.freeze = 1'b0;
        busN.joy_in = '0;
        idle(4);

        // Cocktail: physical P0 coin lands on channel 1, channel 0 meter untouched.
        busN.cocktail = 1'b1;
        runCoin(0, 1, pat, 30, rises, highs, firstRise, lastRise);
        checkOutput("cocktail coin1 rises", 32'(rises), 32'd1);
        checkOutput("cocktail count1", 32'(busN.coin_count[15:8]), 32'd1);
        checkOutput("cocktail count0", 32'(busN.coin_count[7:0]), 32'(expCount0));
        busN.cocktail = 1'b0;
        idle(30);

        // Reset during the third ACTIVE cycle truncates the pulse on the next edge.
        busN.joy_in[COINB] = 1'b1;
        tick();
        busN.joy_in[COINB] = 1'b0;
        idle(4);
        checkOutput("prereset coin", 32'(busN.coin_out[0]), 32'h1);
        reset = 1'b1;
        tick();
        checkOutput("midreset coin", 32'(busN.coin_out[0]), 32'h0);
        checkOutput("midreset count", 32'(busN.coin_count[7:0]), 32'h0);
        reset = 1'b0;
        tick();
        runCoin(0, 0, pat, 30, rises, highs, firstRise, lastRise);
        checkOutput("postreset width", 32'(highs), 32'(PULSE));
        checkOutput("postreset latency", 32'(firstRise), 32'd3);
        checkOutput("postreset count", 32'(busN.coin_count[7:0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/arcade_input_ctrl.md
Name: arcade_input_ctrl

Overview:
- Parametrised input conditioner between the hps_io joystick words and an arcade game core (williams2 and successors).
- Replaces fixed one-player bit slicing with N-player mapping, configurable button count, SOCD cleaning, cocktail player swap, timed coin pulses with coin meters, and a latched pause toggle.
- Runs in clk_sys; all outputs are registered.

Parameters:
- NUM_PLAYERS, 2, number of joystick words handled (1..4).
- BTN_W, 4, action buttons per player (1..8).
- SOCD_NEUTRAL, 1, 1 = opposing directions held together both read 0; 0 = passed through raw.
- COIN_PULSE_CYC, 600000, coin output high time in clk_sys cycles (50 ms at 12 MHz).
- COIN_GAP_CYC, 1200000, forced low time after each pulse before the next coin is accepted.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- joy_in  in  16*NUM_PLAYERS  packed joystick words, player p at [16p+15:16p].
- cocktail  in  1  when 1 and NUM_PLAYERS>=2, players 0 and 1 are swapped.
- freeze  in  1  forces pause off and blocks coins (tie to ioctl_download).
- dir_out  out  4*NUM_PLAYERS  {up,down,left,right} per player.
- btn_out  out  BTN_W*NUM_PLAYERS  action buttons per player.
- start_out  out  NUM_PLAYERS  start per player.
- coin_out  out  NUM_PLAYERS  shaped coin pulse per player.
- coin_count  out  8*NUM_PLAYERS  wrapping coin meter per player.
- pause_out  out  1  latched pause state.

Behaviour:
- Word layout per player: bit0 right, bit1 left, bit2 down, bit3 up; bits 4..4+BTN_W-1 buttons; bit 4+BTN_W start; 5+BTN_W coin; 6+BTN_W pause. Unused bits are ignored.
- Stage 1 register: joy_q <= joy_in (swapped if cocktail). Stage 2: joy_q2 <= joy_q, used for edge detection.
- dir_out, btn_out, start_out are registered from joy_q: latency 2 cycles from joy_in.
- SOCD_NEUTRAL=1: left&right both set -> both 0; up&down both set -> both 0. Other directions are unaffected.
- Pause toggle: a rising edge (joy_q=1, joy_q2=0) of any player's pause bit toggles pause_out.
  - Simultaneous edges from several players produce a single toggle.
  - freeze=1 forces pause_out to 0 and ignores pause edges.
- While pause_out=1: dir_out, btn_out, start_out are forced to 0; coin edges are ignored.
- Coin FSM per player, states IDLE, ACTIVE, GAP, with a down-counter sized by $clog2 of the maximum of the two cycle parameters.
  - IDLE: on a coin rising edge with no pause and no freeze -> ACTIVE, load COIN_PULSE_CYC-1, coin_out<=1, coin_count<=coin_count+1 (mod 256).
  - ACTIVE: counter decrements; at 0 -> GAP, load COIN_GAP_CYC-1, coin_out<=0.
  - GAP: at 0 -> IDLE.
  - Edges in ACTIVE/GAP are dropped, not queued. A held button does not retrigger: a new edge is required.
  - coin_out rises 3 clk_sys edges after joy_in coin rises (stage 1, stage 2, FSM). It stays high exactly COIN_PULSE_CYC cycles.
  - freeze asserting mid-ACTIVE does not truncate the pulse.
- Cocktail swap changes the mapping only; FSM state stays with its physical output channel.
- Reset (sync): all outputs 0, coin_count 0, FSMs IDLE, counters 0, pipeline registers 0. Reset mid-pulse truncates coin_out the next cycle.
- NUM_PLAYERS=1: the cocktail input is ignored.

Decomposition:
- Package arcade_input_pkg holds:
  - bit-offset constants (JOY_RIGHT..JOY_UP, JOY_BTN0) and the functions start_bit(btn_w), coin_bit(btn_w), pause_bit(btn_w);
  - the coin_state_t enum {IDLE, ACTIVE, GAP}.
- One sub-module, coin_pulse_shaper (single-channel FSM, counter and meter), instantiated NUM_PLAYERS times via generate.

Test Plan:
- Use COIN_PULSE_CYC=8, COIN_GAP_CYC=16 on the bench.
- Coin tap: P0 coin bit high 1 cycle -> coin_out[0] high 8 cycles starting 3 cycles later; coin_count[0]=1.
- Coin spam: P0 coin rises again 4 and 12 cycles after the first pulse starts -> no new pulse; an edge after ACTIVE+GAP (24 cycles) -> second pulse, count=2. Holding coin for 100 cycles -> exactly one pulse.
- SOCD: P1 left+right+up held -> dir_out[7:4]=4'b1000 with SOCD_NEUTRAL=1; 4'b1011 with 0.
- Pause: P1 pause tapped -> pause_out=1, dir/btn/start 0, coin taps ignored (count unchanged). P0 and P1 pause tapped the same cycle -> pause_out toggles once back to 0. freeze=1 -> pause_out=0.
- Cocktail: cocktail=1, joy_in P0 button0 set -> btn_out bit BTN_W (player 1) set, bit 0 clear.
- Reset mid-pulse: assert reset during cycle 3 of ACTIVE -> coin_out=0 and coin_count=0 next cycle; a new tap after release produces a full 8-cycle pulse.
